// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
//   Converts single host requests into APB transfers. Each transfer goes
//   IDLE -> SETUP -> ACCESS (one or more cycles) -> RESP. The response is held
//   until the host takes it. An optional timeout aborts an ACCESS phase that
//   never sees i_pready.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles without i_pready before abort (0 = never)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_req_valid / o_req_ready  request handshake
//   i_req_addr/write/wdata     request payload, captured on acceptance
//   o_rsp_valid / i_rsp_ready  response handshake
//   o_rsp_rdata, o_rsp_err     response payload
//   o_psel, o_penable, o_pwrite, o_paddr, o_pwdata   APB master outputs
//   i_prdata, i_pready, i_pslverr                    APB completer inputs
//
// State  | meaning
// IDLE   | waiting for a host request (o_req_ready = 1)
// SETUP  | APB setup phase, psel = 1, penable = 0
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response presented to host until i_rsp_ready
// -----------------------------------------------------------------------------
module apb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [11:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [11:0] o_paddr,
  output logic [31:0] o_pwdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready,
  input  logic        i_pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the wait cycle that brings the count to TIMEOUT_CYCLES,
  // i.e. when the count of earlier wait cycles equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          state_d  = SETUP;
          cnt_d    = '0;
          paddr_d  = i_req_addr;
          pwrite_d = i_req_write;
          pwdata_d = i_req_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout landing on the same cycle
        if (i_pready) begin
          state_d = RESP;
          rdata_d = pwrite_q ? 32'd0 : i_prdata;
          err_d   = i_pslverr;
        end else if (timeout_hit) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign o_penable   = (state_q == ACCESS);
  assign o_rsp_valid = (state_q == RESP);
  assign o_pwrite    = pwrite_q;
  assign o_paddr     = paddr_q;
  assign o_pwdata    = pwdata_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_apb_initiator
//   Self-checking bench for apb_initiator (TIMEOUT_CYCLES = 4). Each transfer
//   is described by its payload, the number of wait states the completer
//   inserts, and how long the host stalls the response; the expected APB
//   phase sequence and response are derived from those numbers.
// -----------------------------------------------------------------------------
module tb_apb_initiator;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [11:0] i_req_addr;
  logic        i_req_write;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [11:0] o_paddr;
  logic [31:0] o_pwdata;
  logic [31:0] i_prdata;
  logic        i_pready;
  logic        i_pslverr;

  int n_checks = 0;
  int n_errors = 0;

  apb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_write (i_req_write),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_psel      (o_psel),
    .o_penable   (o_penable),
    .o_pwrite    (o_pwrite),
    .o_paddr     (o_paddr),
    .o_pwdata    (o_pwdata),
    .i_prdata    (i_prdata),
    .i_pready    (i_pready),
    .i_pslverr   (i_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer. waits = cycles of pready=0 before the ready cycle;
  // hold = extra RESP cycles with i_rsp_ready=0. When pend is set, a new
  // request (p_*) is presented during RESP and left pending on return.
  task automatic do_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prdata, input logic slverr,
                         input int hold, input logic pend, input logic [11:0] p_addr,
                         input logic p_wr, input logic [31:0] p_wdata);
    logic        timeout;
    int          n_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;

    timeout   = (waits >= TO);
    n_acc     = timeout ? TO : waits + 1;
    exp_rdata = (timeout || wr) ? 32'd0 : prdata;
    exp_err   = timeout ? 1'b1 : slverr;

    chk("idle_req_ready", 32'(o_req_ready), 1);
    chk("idle_psel", 32'(o_psel), 0);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_write = wr;
    i_req_wdata = wdata;
    // completer inputs are noise outside ACCESS
    i_pready    = 1'($urandom);
    i_prdata    = $urandom;
    i_pslverr   = 1'($urandom);
    step();

    chk("setup_psel", 32'(o_psel), 1);
    chk("setup_penable", 32'(o_penable), 0);
    chk("setup_req_ready", 32'(o_req_ready), 0);
    chk("setup_paddr", 32'(o_paddr), 32'(addr));
    chk("setup_pwrite", 32'(o_pwrite), 32'(wr));
    chk("setup_pwdata", o_pwdata, wdata);
    // junk request while not ready must be ignored
    i_req_addr  = 12'($urandom);
    i_req_write = 1'($urandom);
    i_req_wdata = $urandom;
    step();

    for (int k = 1; k <= n_acc; k++) begin
      chk("access_psel", 32'(o_psel), 1);
      chk("access_penable", 32'(o_penable), 1);
      chk("access_paddr", 32'(o_paddr), 32'(addr));
      chk("access_pwrite", 32'(o_pwrite), 32'(wr));
      chk("access_pwdata", o_pwdata, wdata);
      chk("access_rsp_valid", 32'(o_rsp_valid), 0);
      i_pready  = (k == waits + 1);
      i_prdata  = (k == waits + 1) ? prdata : $urandom;
      i_pslverr = (k == waits + 1) ? slverr : 1'($urandom);
      step();
    end

    i_req_valid = pend;
    i_req_addr  = p_addr;
    i_req_write = p_wr;
    i_req_wdata = p_wdata;
    i_pready    = 1'($urandom);
    i_prdata    = $urandom;
    i_pslverr   = 1'($urandom);
    i_rsp_ready = 1'b0;
    chk("resp_valid", 32'(o_rsp_valid), 1);
    chk("resp_psel", 32'(o_psel), 0);
    chk("resp_penable", 32'(o_penable), 0);
    chk("resp_rdata", o_rsp_rdata, exp_rdata);
    chk("resp_err", 32'(o_rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      i_pready = 1'($urandom);
      i_prdata = $urandom;
      step();
      chk("hold_valid", 32'(o_rsp_valid), 1);
      chk("hold_rdata", o_rsp_rdata, exp_rdata);
      chk("hold_err", 32'(o_rsp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(o_req_ready), 0);
      chk("hold_psel", 32'(o_psel), 0);
    end
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(o_rsp_valid), 0);
    chk("done_req_ready", 32'(o_req_ready), 1);
    chk("done_psel", 32'(o_psel), 0);
    if (!pend) i_req_valid = 1'b0;
  endtask

  initial begin
    logic [11:0] a;
    logic        w;
    logic [31:0] d;

    rst_n       = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_req_write = 1'b0;
    i_req_wdata = '0;
    i_rsp_ready = 1'b0;
    i_prdata    = '0;
    i_pready    = 1'b0;
    i_pslverr   = 1'b0;
    step();
    step();
    chk("rst_psel", 32'(o_psel), 0);
    chk("rst_penable", 32'(o_penable), 0);
    chk("rst_pwrite", 32'(o_pwrite), 0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rsp_err", 32'(o_rsp_err), 0);
    chk("rst_paddr", 32'(o_paddr), 0);
    chk("rst_pwdata", o_pwdata, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_req_ready", 32'(o_req_ready), 1);

    // write 0xA to 0x010, no wait states, response taken immediately
    do_xfer(12'h010, 1'b1, 32'h0000000A, 0, 32'hDEADBEEF, 1'b0, 0, 1'b0, 12'h0, 1'b0, 32'h0);
    // read 0x020 with 3 wait states
    do_xfer(12'h020, 1'b0, 32'h0, 3, 32'h12345678, 1'b0, 0, 1'b0, 12'h0, 1'b0, 32'h0);
    // read with slave error
    do_xfer(12'h030, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b1, 0, 1'b0, 12'h0, 1'b0, 32'h0);
    // timeout: pready never comes
    do_xfer(12'h040, 1'b0, 32'h0, 10, 32'h11111111, 1'b0, 0, 1'b0, 12'h0, 1'b0, 32'h0);
    // exactly at the limit: 4th wait cycle aborts
    do_xfer(12'h044, 1'b1, 32'h55AA55AA, 4, 32'h22222222, 1'b0, 0, 1'b0, 12'h0, 1'b0, 32'h0);
    // pready on the last allowed cycle completes normally
    do_xfer(12'h048, 1'b0, 32'h0, 3, 32'h33333333, 1'b1, 0, 1'b0, 12'h0, 1'b0, 32'h0);
    // host stalls response 5 cycles with a new request pending
    do_xfer(12'h050, 1'b0, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 5, 1'b1, 12'h0ABC, 1'b1, 32'h87654321);
    do_xfer(12'h0ABC, 1'b1, 32'h87654321, 0, 32'h0, 1'b0, 0, 1'b0, 12'h0, 1'b0, 32'h0);

    // reset in the middle of ACCESS
    i_req_valid = 1'b1;
    i_req_addr  = 12'h055;
    i_req_write = 1'b1;
    i_req_wdata = 32'hFEEDFACE;
    step();
    i_req_valid = 1'b0;
    i_pready    = 1'b0;
    step();
    step();
    chk("mid_access_penable", 32'(o_penable), 1);
    rst_n    = 1'b0;
    i_pready = 1'b1;
    step();
    chk("midrst_psel", 32'(o_psel), 0);
    chk("midrst_penable", 32'(o_penable), 0);
    chk("midrst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("midrst_paddr", 32'(o_paddr), 0);
    rst_n    = 1'b1;
    i_pready = 1'b0;
    step();
    chk("midrst_req_ready", 32'(o_req_ready), 1);
    chk("midrst_no_rsp", 32'(o_rsp_valid), 0);
    step();
    chk("midrst_still_idle", 32'(o_rsp_valid), 0);

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      a = 12'($urandom);
      w = 1'($urandom);
      d = $urandom;
      do_xfer(a, w, d, int'($urandom_range(0, 6)), $urandom, 1'($urandom),
              int'($urandom_range(0, 3)), 1'b0, 12'h0, 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255; it is the number of consecutive ACCESS cycles without i_pready after which the transfer is aborted, and 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_req_valid  input  1  host request valid.
REQ-005 SHALL have port o_req_ready  output  1  request accepted when high together with i_req_valid.
REQ-006 SHALL have port i_req_addr  input  12  byte address, driven unmodified on o_paddr.
REQ-007 SHALL have port i_req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port i_req_wdata  input  32  write data.
REQ-009 SHALL have port o_rsp_valid  output  1  response valid.
REQ-010 SHALL have port i_rsp_ready  input  1  host accepts the response.
REQ-011 SHALL have port o_rsp_rdata  output  32  read data; 0 for writes and aborted transfers.
REQ-012 SHALL have port o_rsp_err  output  1  slave error or timeout.
REQ-013 SHALL have ports o_psel, o_penable, o_pwrite (output, 1 each), o_paddr (output, 12) and o_pwdata (output, 32), forming the APB master outputs.
REQ-014 SHALL have ports i_prdata (input, 32), i_pready (input, 1) and i_pslverr (input, 1), forming the APB completer inputs.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be registered or decoded only from the state register.
REQ-016 SHALL drive o_req_ready high only in IDLE, and SHALL accept a request on the edge where i_req_valid and o_req_ready are both high, then go to SETUP.
REQ-017 SHALL register addr, write and wdata on acceptance and hold o_paddr, o_pwrite and o_pwdata stable from SETUP until ACCESS exits.
REQ-018 SHALL output o_psel=1 and o_penable=0 in SETUP, then move unconditionally to ACCESS after one cycle.
REQ-019 SHALL output o_psel=1 and o_penable=1 in ACCESS, and remain there while i_pready=0 and no timeout has occurred.
REQ-020 SHALL, in ACCESS with i_pready=1:
  - capture o_rsp_rdata = i_prdata for a read, or 0 for a write;
  - capture o_rsp_err = i_pslverr;
  - go to RESP.
REQ-021 SHALL count ACCESS cycles with i_pready=0 in a counter wide enough for TIMEOUT_CYCLES, and clear the counter on entry to SETUP.
REQ-022 SHALL, when TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES with i_pready still 0, abort with o_rsp_err=1 and o_rsp_rdata=0, then go to RESP.
REQ-023 SHALL give i_pready priority if it is high in the same cycle the count reaches TIMEOUT_CYCLES, completing the transfer normally.
REQ-024 SHALL drive o_psel=0 and o_penable=0 in IDLE and RESP; there are no back-to-back APB transfers without an idle cycle.
REQ-025 SHALL hold o_rsp_valid=1 in RESP, keeping o_rsp_rdata and o_rsp_err stable until i_rsp_ready=1, then go to IDLE.
REQ-026 SHALL achieve a minimum latency of 3 cycles, acceptance edge to o_rsp_valid, with 0 wait states; each wait state adds 1 cycle.
REQ-027 SHALL ignore i_prdata, i_pready and i_pslverr outside ACCESS.
REQ-028 SHALL ignore i_req_* while o_req_ready=0.

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge, set state=IDLE, clear the timeout counter, and set:
  - o_psel, o_penable, o_pwrite and o_rsp_valid to 0;
  - o_rsp_err to 0;
  - o_paddr, o_pwdata and o_rsp_rdata to 0.
REQ-030 SHALL abandon any in-flight transfer immediately on reset, including one in SETUP, ACCESS or RESP, with o_psel=0 on the next cycle and no response issued.
REQ-031 SHALL drive o_req_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-032 SHALL verify a write of 0x0000000A to addr 0x010 with i_pready=1 and i_rsp_ready=1:
  - SETUP at cycle 1 (psel=1, penable=0), ACCESS at cycle 2;
  - o_rsp_valid at cycle 3 with err=0 and rdata=0.
REQ-033 SHALL verify a read of addr 0x020 with i_pready low for 3 ACCESS cycles and i_prdata=0x12345678 on the ready cycle:
  - o_rsp_rdata=0x12345678 and err=0;
  - o_paddr stable at 0x020 throughout the transfer.
REQ-034 SHALL verify a read with i_pready=1 and i_pslverr=1 -> o_rsp_err=1 with rdata equal to i_prdata.
REQ-035 SHALL verify, with TIMEOUT_CYCLES=4 and i_pready held at 0:
  - exactly 4 ACCESS cycles, then psel=0;
  - o_rsp_valid with err=1 and rdata=0.
REQ-036 SHALL verify that holding i_rsp_ready=0 for 5 cycles:
  - keeps o_rsp_valid and its data stable, with o_req_ready=0;
  - leaves a pending i_req_valid unaccepted until the cycle after the response is accepted.
REQ-037 SHALL verify that asserting rst_n=0 for 1 cycle mid-ACCESS gives psel=0, penable=0 and o_rsp_valid=0 on the next cycle, and o_req_ready=1 after reset is released.
